cpri_txdata_pack: RTL and testbench

CPRI_TXDATA_PACK -- requirements
Module: cpri_txdata_pack

---
 rtl/cpri_pkg.sv | 55 +++++
 rtl/cpri_gearbox_14to16.sv | 56 +++++
 rtl/cpri_txdata_pack.sv | 99 +++++++++
 tb/tb_cpri_txdata_pack.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpri_pkg.sv
// Shared CPRI TX constants, slot classification and the control-word table.
package cpri_pkg;

    localparam int unsigned SEQ_W         = 7;
    localparam int unsigned X_W           = 8;
    localparam int unsigned DATA_W        = 64;
    localparam int unsigned CTRL_W        = 8;
    localparam int unsigned SEQ_MAX       = 95;
    localparam int unsigned SEQ_HDR0      = 4;
    localparam int unsigned SEQ_PAY_FIRST = 6;
    localparam int unsigned SEQ_PAY_LAST  = 89;
    localparam int unsigned X_MAX         = 255;

    localparam logic [DATA_W-1:0] CW_X81  = 64'h5100_0000_0000_0000;
    localparam logic [DATA_W-1:0] CW_X144 = 64'h9000_0000_0000_0000;
    localparam logic [DATA_W-1:0] CW_X145 = 64'h9100_0000_0000_0000;
    localparam logic [DATA_W-1:0] CW_X208 = 64'hD000_0000_0000_0000;
    localparam logic [DATA_W-1:0] CW_X209 = 64'hD100_0000_0000_0000;

    typedef enum logic [1:0] {
        SLOT_CTRL,
        SLOT_ZERO,
        SLOT_HDR,
        SLOT_PAY
    } slot_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
        logic [CTRL_W-1:0] ctrl;
        logic [X_W-1:0]    x;
        logic              underflow;
    } tx_word_t;

    // Content class of the word at a given seq position.
    function automatic slot_e slot_of(input logic [SEQ_W-1:0] seq);
        if (seq <= SEQ_W'(1))                  return SLOT_CTRL;
        else if (seq < SEQ_W'(SEQ_HDR0))       return SLOT_ZERO;
        else if (seq < SEQ_W'(SEQ_PAY_FIRST))  return SLOT_HDR;
        else if (seq <= SEQ_W'(SEQ_PAY_LAST))  return SLOT_PAY;
        else                                   return SLOT_ZERO;
    endfunction

    function automatic logic [DATA_W-1:0] ctrl_word(input logic [X_W-1:0] x);
        case (x)
            X_W'(81):  return CW_X81;
            X_W'(144): return CW_X144;
            X_W'(145): return CW_X145;
            X_W'(208): return CW_X208;
            X_W'(209): return CW_X209;
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/cpri_gearbox_14to16.sv
// 14-bit to 16-bit gearbox: LSB-first 48-bit bit buffer with fill count and push-ready.
module cpri_gearbox_14to16 #(
    parameter int unsigned SW = 14
) (
    input  logic          i_clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push_vld,
    input  logic [SW-1:0] push_data,
    input  logic          pop_req,
    output logic          push_rdy_c,
    output logic          pop_ok_c,
    output logic [15:0]   pop_data_c
);

    localparam int unsigned BUF_W  = 48;
    localparam int unsigned POP_W  = 16;
    localparam int unsigned FILL_W = 6;

    logic [BUF_W-1:0]  bit_buf;
    logic [BUF_W-1:0]  merged;
    logic [BUF_W-1:0]  buf_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic              push;

    // New sample lands above the current fill; a pop drops the 16 oldest bits.
    always_comb begin
        push_rdy_c = (fill <= FILL_W'(BUF_W - SW)) && !clear && !reset;
        push       = push_vld && push_rdy_c;
        pop_ok_c   = pop_req && (fill >= FILL_W'(POP_W));
        pop_data_c = bit_buf[POP_W-1:0];
        merged     = bit_buf;
        fill_nxt   = fill;
        if (push) begin
            merged   = bit_buf | (BUF_W'(push_data) << fill);
            fill_nxt = fill + FILL_W'(SW);
        end
        buf_nxt = merged;
        if (pop_ok_c) begin
            buf_nxt  = merged >> POP_W;
            fill_nxt = fill_nxt - FILL_W'(POP_W);
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset || clear) begin
            bit_buf <= '0;
            fill    <= '0;
        end else begin
            bit_buf <= buf_nxt;
            fill    <= fill_nxt;
        end
    end

endmodule

// File: rtl/cpri_txdata_pack.sv
// CPRI TX basic-frame word packer: control/header/payload words on a 96-word sequence.
// Define CPRI_TX_CM_EN to send the x-indexed control-word table at seq 0-1.
module cpri_txdata_pack
    import cpri_pkg::*;
#(
    parameter logic [63:0] HDR_WORD = 64'h11114321_11114321,
    parameter int unsigned SW       = 14
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              i_hfp,
    input  logic [SW-1:0]     i_iq_sample,
    input  logic              i_iq_vld,
    output logic              o_iq_rdy,
    output logic [63:0]       o_cpri_tx_data,
    output logic [6:0]        o_cpri_tx_seq,
    output logic [7:0]        o_cpri_tx_ctrl,
    output logic [7:0]        o_cpri_tx_x,
    output logic              o_underflow
);

    logic [SEQ_W-1:0] seq_cur, seq_sel, seq_nxt;
    logic [X_W-1:0]   x_cur, x_sel, x_nxt;
    slot_e            slot;
    logic             pop_req;
    logic             pop_ok;
    logic [15:0]      pop_data;
    tx_word_t         word_d, word_q;

    cpri_gearbox_14to16 #(.SW(SW)) u_gearbox (
        .i_clk      (i_clk),
        .reset      (reset),
        .clear      (i_hfp),
        .push_vld   (i_iq_vld),
        .push_data  (i_iq_sample),
        .pop_req    (pop_req),
        .push_rdy_c (o_iq_rdy),
        .pop_ok_c   (pop_ok),
        .pop_data_c (pop_data)
    );

    // seq_cur/x_cur name the word produced at the next edge; i_hfp forces it to 0/0.
    always_comb begin
        seq_sel = seq_cur;
        x_sel   = x_cur;
        if (i_hfp) begin
            seq_sel = '0;
            x_sel   = '0;
        end
        seq_nxt = seq_sel + SEQ_W'(1);
        x_nxt   = x_sel;
        if (seq_sel == SEQ_W'(SEQ_MAX)) begin
            seq_nxt = '0;
            x_nxt   = (x_sel == X_W'(X_MAX)) ? '0 : x_sel + X_W'(1);
        end

        slot    = slot_of(seq_sel);
        pop_req = (slot == SLOT_PAY);

        word_d     = '0;
        word_d.seq = seq_sel;
        word_d.x   = x_sel;
        case (slot)
            SLOT_CTRL: begin
                word_d.ctrl = 8'hFF;
`ifdef CPRI_TX_CM_EN
                word_d.data = ctrl_word(x_sel);
`else
                word_d.data = '0;
`endif
            end
            SLOT_HDR: word_d.data = HDR_WORD;
            SLOT_PAY: begin
                word_d.data      = pop_ok ? {4{pop_data}} : '0;
                word_d.underflow = !pop_ok;
            end
            default: word_d.data = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            seq_cur <= '0;
            x_cur   <= '0;
            word_q  <= '0;
        end else begin
            seq_cur <= seq_nxt;
            x_cur   <= x_nxt;
            word_q  <= word_d;
        end
    end

    assign o_cpri_tx_data = word_q.data;
    assign o_cpri_tx_seq  = word_q.seq;
    assign o_cpri_tx_ctrl = word_q.ctrl;
    assign o_cpri_tx_x    = word_q.x;
    assign o_underflow    = word_q.underflow;

endmodule

// File: tb/tb_cpri_txdata_pack.sv
// Scoreboard bench for cpri_txdata_pack: bit-queue reference model vs. registered word stream.
module tb_cpri_txdata_pack;

    localparam logic [63:0] HDR = 64'h11114321_11114321;

    logic        i_clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_hfp = 1'b0;
    logic        i_iq_vld = 1'b0;
    logic [13:0] i_iq_sample = '0;
    logic        o_iq_rdy;
    logic [63:0] o_cpri_tx_data;
    logic [6:0]  o_cpri_tx_seq;
    logic [7:0]  o_cpri_tx_ctrl;
    logic [7:0]  o_cpri_tx_x;
    logic        o_underflow;

    cpri_txdata_pack dut (
        .i_clk          (i_clk),
        .reset          (reset),
        .i_hfp          (i_hfp),
        .i_iq_sample    (i_iq_sample),
        .i_iq_vld       (i_iq_vld),
        .o_iq_rdy       (o_iq_rdy),
        .o_cpri_tx_data (o_cpri_tx_data),
        .o_cpri_tx_seq  (o_cpri_tx_seq),
        .o_cpri_tx_ctrl (o_cpri_tx_ctrl),
        .o_cpri_tx_x    (o_cpri_tx_x),
        .o_underflow    (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0] data;
        int          seq;
        logic [7:0]  ctrl;
        int          x;
        logic        uf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    // Reference model: word position, frame index, and the stream as a FIFO of bits.
    int   m_seq = 0;
    int   m_x = 0;
    bit   m_bits[$];
    int   low_run = 0;
    int   max_low_run = 0;

    function automatic logic [63:0] cm_word(input int x);
`ifdef CPRI_TX_CM_EN
        case (x)
            81:      return 64'h5100_0000_0000_0000;
            144:     return 64'h9000_0000_0000_0000;
            145:     return 64'h9100_0000_0000_0000;
            208:     return 64'hD000_0000_0000_0000;
            209:     return 64'hD100_0000_0000_0000;
            default: return 64'h0;
        endcase
`else
        return (x < 0) ? 64'h1 : 64'h0;
`endif
    endfunction

    // One clock: drive inputs, check ready, queue the expected word, advance the model.
    task automatic cycle(input bit rst, input bit hfp, input bit vld,
                         input logic [13:0] smp, output bit acc);
        exp_t        e;
        bit          rdy_e;
        logic [15:0] p;
        @(negedge i_clk);
        reset       = rst;
        i_hfp       = hfp;
        i_iq_vld    = vld;
        i_iq_sample = smp;
        #1;
        rdy_e = !rst && !hfp && (m_bits.size() <= 34);
        acc   = vld && rdy_e;
        total++;
        if (o_iq_rdy !== rdy_e) begin
            bad++;
            $display("FAIL rdy t=%0t got=%b exp=%b", $time, o_iq_rdy, rdy_e);
        end
        if (vld && !rst && !hfp && !o_iq_rdy) low_run++;
        else low_run = 0;
        if (low_run > max_low_run) max_low_run = low_run;

        e = '{64'h0, 0, 8'h00, 0, 1'b0};
        if (rst) begin
            m_seq = 0;
            m_x   = 0;
            m_bits.delete();
        end else begin
            if (hfp) begin
                m_seq = 0;
                m_x   = 0;
                m_bits.delete();
            end
            e.seq  = m_seq;
            e.x    = m_x;
            e.ctrl = (m_seq < 2) ? 8'hFF : 8'h00;
            if (m_seq < 2) e.data = cm_word(m_x);
            else if (m_seq == 4 || m_seq == 5) e.data = HDR;
            else if (m_seq >= 6 && m_seq <= 89) begin
                if (m_bits.size() >= 16) begin
                    for (int i = 0; i < 16; i++) p[i] = m_bits.pop_front();
                    e.data = {4{p}};
                end else begin
                    e.uf = 1'b1;
                end
            end
            if (acc) for (int i = 0; i < 14; i++) m_bits.push_back(smp[i]);
            if (m_seq == 95) begin
                m_seq = 0;
                m_x   = (m_x + 1) % 256;
            end else begin
                m_seq++;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: every clock presents one word; compare it to the oldest expectation.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                total++;
                if (o_cpri_tx_data !== mon_e.data || o_cpri_tx_seq !== 7'(mon_e.seq) ||
                    o_cpri_tx_ctrl !== mon_e.ctrl || o_cpri_tx_x !== 8'(mon_e.x) ||
                    o_underflow !== mon_e.uf) begin
                    bad++;
                    $display("FAIL word t=%0t got d=%h s=%0d c=%h x=%0d u=%b exp d=%h s=%0d c=%h x=%0d u=%b",
                             $time, o_cpri_tx_data, o_cpri_tx_seq, o_cpri_tx_ctrl, o_cpri_tx_x,
                             o_underflow, mon_e.data, mon_e.seq, mon_e.ctrl, mon_e.x, mon_e.uf);
                end
            end
        end
    end

    initial begin
        bit          acc;
        logic [13:0] smp;
        int          n_acc;

        repeat (3) cycle(1'b1, 1'b0, 1'b0, 14'h0, acc);

        // Continuous valid for 10 frames; first two samples 1 and 2.
        smp = 14'h0001;
        n_acc = 0;
        max_low_run = 0;
        repeat (960) begin
            cycle(1'b0, 1'b0, 1'b1, smp, acc);
            if (acc) begin
                n_acc++;
                smp = (n_acc == 1) ? 14'h0002 : 14'($urandom);
            end
        end
        total++;
        if (max_low_run > 16) begin
            bad++;
            $display("FAIL rdy_stuck got_run=%0d exp_max=16", max_low_run);
        end

        // Starve the gearbox for a frame, then resume.
        repeat (110) cycle(1'b0, 1'b0, 1'b0, 14'($urandom), acc);
        repeat (192) begin
            cycle(1'b0, 1'b0, 1'b1, smp, acc);
            if (acc) smp = 14'($urandom);
        end

        // Hyperframe pulse at seq 50 with a valid sample presented.
        for (int i = 0; i < 200 && m_seq != 50; i++) begin
            cycle(1'b0, 1'b0, ($urandom % 4) != 0, smp, acc);
            if (acc) smp = 14'($urandom);
        end
        cycle(1'b0, 1'b1, 1'b1, smp, acc);
        repeat (200) begin
            cycle(1'b0, 1'b0, ($urandom % 4) != 0, smp, acc);
            if (acc) smp = 14'($urandom);
        end

        // Mid-frame reset, then a long run that walks x past 144 and through its wrap.
        repeat (2) cycle(1'b1, 1'b0, 1'b1, smp, acc);
        repeat (257 * 96) begin
            cycle(1'b0, 1'b0, ($urandom % 8) != 0, smp, acc);
            if (acc) smp = 14'($urandom);
        end

        cycle(1'b0, 1'b0, 1'b0, 14'h0, acc);
        repeat (2) @(posedge i_clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got_pending=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
